connect4_move_controller: RTL and testbench
===========================================

# connect4_move_controller

Turn sequencer for the Connect4 board counter. It accepts column requests from two players and only acts on the player whose turn it is. It checks that the requested column is valid and not full, then drives the counter's one-hot active-low `column` select and a single-cycle `add` pulse. It alternates turns, counts total moves and detects a draw. It sits between the player input logic and the per-column 3-bit counter bank (`count[11:0]`), and consumes the win detector's `game_over` flag.

## Interface
- `ROWS`, default 6: capacity of each column; legal range 1..7.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `p1_col`  input  4  player 1 column select, one-hot active-low (4'b1110 = column 0).
- `p1_req`  input  1  player 1 move request, level; acted on at its rising edge.
- `p2_col`  input  4  player 2 column select, same encoding as `p1_col`.
- `p2_req`  input  1  player 2 move request, same rules as `p1_req`.
- `count`  input  12  counter bank fill levels; bits [3k+2:3k] = column k.
- `game_over`  input  1  win detected; level.
- `column`  output  4  column select to the counter bank; 4'b1111 = none.
- `add`  output  1  one-cycle increment strobe to the counter bank.
- `turn`  output  1  0 = player 1 to move, 1 = player 2 to move.
- `move_ack`  output  1  one-cycle pulse when a move completes.
- `move_reject`  output  1  one-cycle pulse when a request is refused.
- `draw`  output  1  sticky; board full with no win.
- `done`  output  1  sticky; game finished (win or draw).

## Operation
- The active requester is `p1_*` when `turn=0` and `p2_*` when `turn=1`.
- The inactive player's `req` is ignored completely, including when both players request in the same cycle.
- A request edge is detected as follows:
  - `req` is registered every cycle.
  - An edge is `req & ~req_q` on the active player's line.
  - `req_q` resets to 0.
- Validity: the column code must have exactly one zero bit, and that column's count field must be `< ROWS`.
- FSM states are WAIT, ISSUE, SETTLE, CHECK and OVER.
- WAIT:
  - `game_over=1` → OVER.
  - Valid edge → latch the column code, go to ISSUE.
  - Invalid edge → `move_reject=1` next cycle, stay in WAIT, `turn` unchanged.
- ISSUE:
  - `column` = latched code, `add=1` for exactly this cycle.
  - `moves` increments by 1.
  - Go to SETTLE.
- SETTLE:
  - `add=0`, `column` holds the latched code.
  - Allows the counter update to propagate.
  - Go to CHECK.
- CHECK:
  - `column` = 4'b1111.
  - If `game_over=1` → `done=1`, go to OVER.
  - Else if `moves == 4*ROWS` → `draw=1`, `done=1`, go to OVER.
  - Else toggle `turn` and go to WAIT.
  - In all three cases `move_ack` pulses in the cycle after CHECK.
- OVER:
  - Terminal state; all requests are ignored and produce no reject.
  - `done=1` is held; only reset exits.
- `moves` is a 5-bit register and saturates at 4*ROWS; it never wraps.
- Requests arriving during ISSUE, SETTLE or CHECK are not queued. An edge that occurs in those states is lost, and the player must release and re-press.

## Timing
- Reset values: `column`=4'b1111, `add`=0, `turn`=0, `move_ack`=0, `move_reject`=0, `draw`=0, `done`=0, `moves`=0, state=WAIT, `req_q`=0.
- Reset is asynchronous: all outputs reach their reset values immediately on assertion, even in the middle of an ISSUE cycle.
- Accepted move, with the request edge sampled at clock edge N:
  - ISSUE during cycle N+1 (`add`=1).
  - SETTLE during N+2.
  - CHECK during N+3.
  - `move_ack` and the new `turn` are visible during N+4.
- Rejected move: `move_reject` is high during cycle N+1 only.
- Minimum spacing between accepted moves is 4 cycles.
- All outputs are registered; none is combinational from an input.
- `game_over` asserting while in ISSUE or SETTLE does not cancel the `add` already issued; the transition to OVER happens in CHECK.

## Test plan
- Reset, then a p1 edge with `p1_col`=4'b1110 and `count`=0 → `add` for exactly 1 cycle with `column`=4'b1110, `move_ack` 3 cycles later, then `turn`=1.
- With `turn`=0, a `p2_req` edge, then simultaneous p1/p2 edges with `p1_col`=4'b1101 → p2 is ignored and only `column`=4'b1101 is added.
- Invalid codes 4'b1100 and 4'b1111, and a full column (`count`[5:3]=6) → `move_reject` pulses, no `add`, `turn` unchanged.
- Fill the board with 24 alternating valid moves and `game_over`=0 → `draw`=1 and `done`=1 after the 24th move; a further request produces neither `add` nor `move_reject`.
- `game_over` raised in SETTLE → the `add` has already occurred, CHECK goes to OVER, `done`=1, `draw`=0, `turn` not toggled.
- Assert `reset` low during ISSUE → `add` drops to 0 and `column`=4'b1111 immediately; after release, `turn`=0, `moves`=0, state is WAIT, and a new request is accepted.

Source files
------------

// File: rtl/connect4_move_controller.sv
// Turn sequencer for the Connect4 counter bank: validates the active player's column
// request, issues a one-cycle add, alternates turns, and tracks moves and draws.
module connect4_move_controller #(
  parameter int ROWS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  p1_col,
  input  logic        p1_req,
  input  logic [3:0]  p2_col,
  input  logic        p2_req,
  input  logic [11:0] count,
  input  logic        game_over,
  output logic [3:0]  column,
  output logic        add,
  output logic        turn,
  output logic        move_ack,
  output logic        move_reject,
  output logic        draw,
  output logic        done
);

  localparam logic [4:0] MAXMV = 5'(4 * ROWS);
  localparam logic [2:0] ROWS3 = 3'(ROWS);

  typedef enum logic [2:0] {WAIT, ISSUE, SETTLE, CHECK, OVER} state_t;

  state_t      state, state_nxt;
  logic        p1_q, p2_q;
  logic [3:0]  col_lat, col_lat_nxt;
  logic [4:0]  moves, moves_nxt;
  logic [3:0]  column_nxt;
  logic        add_nxt, turn_nxt, ack_nxt, rej_nxt, draw_nxt, done_nxt;

  logic        act_req, act_q, req_edge, one_zero, valid;
  logic [3:0]  act_col, col_inv;
  logic [2:0]  fill;

  // Only the player whose turn it is can produce an edge.
  assign act_req  = turn ? p2_req : p1_req;
  assign act_q    = turn ? p2_q   : p1_q;
  assign act_col  = turn ? p2_col : p1_col;
  assign req_edge = act_req & ~act_q;
  assign col_inv  = ~act_col;
  assign one_zero = (col_inv != 4'd0) && ((col_inv & (col_inv - 4'd1)) == 4'd0);

  always_comb begin
    fill = 3'd0;
    case (act_col)
      4'b1110: fill = count[2:0];
      4'b1101: fill = count[5:3];
      4'b1011: fill = count[8:6];
      4'b0111: fill = count[11:9];
      default: fill = 3'd0;
    endcase
  end

  assign valid = one_zero && (fill < ROWS3);

  always_comb begin
    state_nxt   = state;
    col_lat_nxt = col_lat;
    moves_nxt   = moves;
    column_nxt  = 4'b1111;
    add_nxt     = 1'b0;
    turn_nxt    = turn;
    ack_nxt     = 1'b0;
    rej_nxt     = 1'b0;
    draw_nxt    = draw;
    done_nxt    = done;
    case (state)
      WAIT: begin
        if (game_over) begin
          state_nxt = OVER;
          done_nxt  = 1'b1;
        end else if (req_edge) begin
          if (valid) begin
            state_nxt   = ISSUE;
            col_lat_nxt = act_col;
            column_nxt  = act_col;
            add_nxt     = 1'b1;
            if (moves != MAXMV) moves_nxt = moves + 5'd1;
          end else begin
            rej_nxt = 1'b1;
          end
        end
      end
      // Column stays driven through SETTLE so the counter sees a stable select.
      ISSUE:  begin
        column_nxt = col_lat;
        state_nxt  = SETTLE;
      end
      SETTLE: state_nxt = CHECK;
      CHECK: begin
        ack_nxt = 1'b1;
        if (game_over) begin
          state_nxt = OVER;
          done_nxt  = 1'b1;
        end else if (moves == MAXMV) begin
          state_nxt = OVER;
          draw_nxt  = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          turn_nxt  = ~turn;
          state_nxt = WAIT;
        end
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      col_lat     <= 4'b1111;
      moves       <= 5'd0;
      column      <= 4'b1111;
      add         <= 1'b0;
      turn        <= 1'b0;
      move_ack    <= 1'b0;
      move_reject <= 1'b0;
      draw        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      p1_q        <= p1_req;
      p2_q        <= p2_req;
      col_lat     <= col_lat_nxt;
      moves       <= moves_nxt;
      column      <= column_nxt;
      add         <= add_nxt;
      turn        <= turn_nxt;
      move_ack    <= ack_nxt;
      move_reject <= rej_nxt;
      draw        <= draw_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_connect4_move_controller.sv
// Randomized bench for connect4_move_controller against a transaction-level game model.
module tb_connect4_move_controller;
  localparam int ROWS = 6;

  logic        clk, reset;
  logic [3:0]  p1_col, p2_col;
  logic        p1_req, p2_req;
  logic [11:0] count;
  logic        game_over;
  logic [3:0]  column;
  logic        add, turn, move_ack, move_reject, draw, done;

  connect4_move_controller #(.ROWS(ROWS)) dut (
    .clk(clk), .reset(reset),
    .p1_col(p1_col), .p1_req(p1_req), .p2_col(p2_col), .p2_req(p2_req),
    .count(count), .game_over(game_over),
    .column(column), .add(add), .turn(turn), .move_ack(move_ack),
    .move_reject(move_reject), .draw(draw), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // game model
  int fill_m [4];
  int moves_m;
  bit turn_m, done_m, draw_m, over_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_count();
    for (int i = 0; i < 4; i++) count[3*i +: 3] = 3'(fill_m[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) fill_m[i] = 0;
    moves_m = 0; turn_m = 0; done_m = 0; draw_m = 0; over_m = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    p1_req = 0; p2_req = 0; p1_col = 4'hF; p2_col = 4'hF; game_over = 0;
    model_reset();
    drive_count();
    #1;
    chk("rst_outs", 32'({column, add, turn, move_ack, move_reject, draw, done}),
        32'({4'hF, 6'b0}));
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // who: 1 = p1 only, 2 = p2 only, 3 = both; go_k: cycle after the edge to raise game_over
  task automatic do_req(input int who, input logic [3:0] c1, input logic [3:0] c2, input int go_k);
    logic [3:0] acol;
    logic [6:0] expv;
    bit active, valid, acc, rej;
    int nz, idx;
    acol   = turn_m ? c2 : c1;
    active = !over_m && ((who == 3) || (who == 1 && !turn_m) || (who == 2 && turn_m));
    nz = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!acol[i]) begin nz++; idx = i; end
    valid = (nz == 1) && (fill_m[idx] < ROWS);
    acc = active && valid;
    rej = active && !valid;
    @(negedge clk);
    if (who != 2) begin p1_col = c1; p1_req = 1'b1; end
    if (who != 1) begin p2_col = c2; p2_req = 1'b1; end
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      expv = {acc && k == 1, (acc && k <= 2) ? acol : 4'hF, rej && k == 1, acc && k == 4};
      chk($sformatf("cyc%0d", k), 32'({add, column, move_reject, move_ack}), 32'(expv));
      if (acc && k == 1) begin fill_m[idx]++; drive_count(); end
      if (go_k == k) game_over = 1'b1;
    end
    if (acc) moves_m++;
    if (!over_m) begin
      if (go_k > 0) begin
        over_m = 1; done_m = 1;
      end else if (acc && moves_m == 4*ROWS) begin
        over_m = 1; done_m = 1; draw_m = 1;
      end else if (acc) turn_m = !turn_m;
    end
    chk("turn", 32'(turn), 32'(turn_m));
    chk("done", 32'(done), 32'(done_m));
    chk("draw", 32'(draw), 32'(draw_m));
    p1_req = 0; p2_req = 0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_col();
    logic [3:0] c;
    if ($urandom_range(0, 99) < 85) c = ~(4'b0001 << $urandom_range(0, 3));
    else c = 4'($urandom);
    return c;
  endfunction

  initial begin
    logic [3:0] c;
    int w, r;
    reset = 1'b1; p1_req = 0; p2_req = 0; p1_col = 4'hF; p2_col = 4'hF;
    game_over = 0; count = '0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_async", 32'({column, add, turn, done}), 32'({4'hF, 3'b0}));
    do_reset();

    // directed: first move, ignored p2, simultaneous requests, invalid codes
    do_req(1, 4'b1110, 4'hF, 0);
    do_req(1, 4'b1101, 4'hF, 0);       // turn=1, so p1 is ignored
    do_req(2, 4'hF, 4'b1011, 0);
    do_req(2, 4'hF, 4'b1110, 0);       // turn=0 now, p2 ignored
    do_req(3, 4'b1101, 4'b0111, 0);    // only p1's column is used
    do_req(2, 4'hF, 4'b1100, 0);
    do_req(2, 4'hF, 4'b1111, 0);

    // random play, then fill to a draw
    for (int it = 0; it < 60 && !over_m; it++) begin
      r = $urandom_range(0, 99);
      w = (r < 80) ? (turn_m ? 2 : 1) : (r < 90 ? (turn_m ? 1 : 2) : 3);
      do_req(w, rnd_col(), rnd_col(), 0);
    end
    for (int it = 0; it < 60 && !over_m; it++) begin
      c = 4'hF;
      for (int i = 3; i >= 0; i--) if (fill_m[i] < ROWS) c = ~(4'b0001 << i);
      do_req(turn_m ? 2 : 1, c, c, 0);
    end
    chk("draw_reached", 32'(draw), 32'(1));
    for (int i = 0; i < 4; i++) fill_m[i] = 0;
    drive_count();
    do_req(turn_m ? 2 : 1, 4'b1110, 4'b1110, 0);   // over: no add, no reject

    // game_over raised during SETTLE
    do_reset();
    do_req(1, 4'b1011, 4'hF, 2);
    do_req(1, 4'b1110, 4'b1110, 0);

    // reset asserted mid-ISSUE
    do_reset();
    @(negedge clk);
    p1_col = 4'b0111; p1_req = 1'b1;
    @(posedge clk);
    #2;
    chk("issue_add", 32'({add, column}), 32'({1'b1, 4'b0111}));
    reset = 1'b0;
    #1;
    chk("mid_rst", 32'({add, column, turn}), 32'({1'b0, 4'hF, 1'b0}));
    p1_req = 1'b0;
    model_reset();
    drive_count();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(1, 4'b0111, 4'hF, 0);
    do_req(2, 4'hF, 4'b0111, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
